// File: rtl/sweep_capture_pkg.sv
// rtl/sweep_capture_pkg.sv - shared types and constants for the sweep capture block
package sweep_capture_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WAIT,
        ST_SETTLE,
        ST_MEASURE,
        ST_PUSH
    } state_t;

    // Width of the settle/window counters and their parameter buffers
    localparam int CNT_W = 16;

    // Width of the DDS tuning word carried with each result
    localparam int FWORD_W = 32;

    // Result FIFO entry is {tuning word, peak-to-peak}
    function automatic int entry_width(input int adc_w);
        return FWORD_W + adc_w;
    endfunction

endpackage

// File: rtl/sweep_capture_fifo.sv
// rtl/sweep_capture_fifo.sv - synchronous first-word-fall-through result FIFO
module sweep_capture_fifo #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 44
) (
    input  logic                       clk,
    input  logic                       rstn,
    input  logic                       push_i,
    input  logic [WIDTH-1:0]           wdata_i,
    input  logic                       pop_i,
    output logic [WIDTH-1:0]           rdata_o,
    output logic                       full_o,
    output logic                       empty_o,
    output logic [$clog2(DEPTH):0]     level_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q;
    logic [AW-1:0]    rd_ptr_q;
    logic [LW-1:0]    level_q;
    logic             do_push;
    logic             do_pop;

    assign full_o  = (level_q == LW'(DEPTH));
    assign empty_o = (level_q == '0);
    assign level_o = level_q;

    // A push into a full FIFO is dropped; a pop on empty is ignored
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;

    // Head is visible whenever data is held; reads zero when empty
    assign rdata_o = empty_o ? '0 : mem_q[rd_ptr_q];

    // Storage array, written only on an accepted push
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= wdata_i;
        end
    end

    // Pointers and occupancy; simultaneous push and pop leave the level unchanged
    always_ff @(posedge clk) begin
        if (!rstn) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_q <= wr_ptr_q + AW'(1);
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   level_q <= level_q + LW'(1);
                2'b01:   level_q <= level_q - LW'(1);
                default: level_q <= level_q;
            endcase
        end
    end

endmodule

// File: rtl/sweep_capture.sv
// rtl/sweep_capture.sv - per-frequency-point peak-to-peak capture during a DDS sweep
module sweep_capture
    import sweep_capture_pkg::*;
#(
    parameter int FIFO_DEPTH = 16,
    parameter int ADC_W      = 12
) (
    input  logic                          clk,
    input  logic                          rstn,
    input  logic                          param_wen,
    input  logic [15:0]                   settle_cycles,
    input  logic [15:0]                   window_cycles,
    input  logic                          cap_en,
    input  logic [31:0]                   fword,
    input  logic [ADC_W-1:0]              adc_data,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [31:0]                   out_fword,
    output logic [ADC_W-1:0]              out_pp,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic                          overflow,
    output logic                          busy
);

    localparam int ENTRY_W = entry_width(ADC_W);

    state_t             state_q;
    logic [FWORD_W-1:0] fword_q;
    logic [FWORD_W-1:0] point_q;
    logic [CNT_W-1:0]   settle_buf_q;
    logic [CNT_W-1:0]   window_buf_q;
    logic [CNT_W-1:0]   win_cur_q;
    logic [CNT_W-1:0]   cnt_q;
    logic [ADC_W-1:0]   min_q;
    logic [ADC_W-1:0]   max_q;
    logic               first_q;
    logic               busy_q;
    logic               overflow_q;

    logic               change;
    logic               start;
    logic [CNT_W-1:0]   win_eff;
    logic               push_en;
    logic               fifo_full;
    logic               fifo_empty;
    logic [ENTRY_W-1:0] fifo_wdata;
    logic [ENTRY_W-1:0] fifo_rdata;

    assign change = (fword != fword_q);

    // IDLE starts a point unconditionally; every other state restarts on a new word
    assign start = (state_q == ST_IDLE) || change;

    // A zero-length window still takes one sample
    assign win_eff = (window_buf_q == '0) ? CNT_W'(1) : window_buf_q;

    // A point leaving PUSH is written unless capture was dropped on that cycle
    assign push_en    = (state_q == ST_PUSH) && cap_en;
    assign fifo_wdata = {point_q, max_q - min_q};

    // Sweep sequencer: settle after each tuning-word change, then measure, then push
    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q      <= ST_IDLE;
            fword_q      <= '0;
            point_q      <= '0;
            settle_buf_q <= '0;
            window_buf_q <= '0;
            win_cur_q    <= '0;
            cnt_q        <= '0;
            min_q        <= '0;
            max_q        <= '0;
            first_q      <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            fword_q <= fword;
            if (param_wen) begin
                settle_buf_q <= settle_cycles;
                window_buf_q <= window_cycles;
            end
            if (!cap_en) begin
                state_q <= ST_IDLE;
                cnt_q   <= '0;
                busy_q  <= 1'b0;
            end else if (start) begin
                // Parameters are frozen here for the whole point
                point_q   <= fword;
                win_cur_q <= win_eff;
                first_q   <= 1'b1;
                busy_q    <= 1'b1;
                if (settle_buf_q == '0) begin
                    state_q <= ST_MEASURE;
                    cnt_q   <= win_eff;
                end else begin
                    state_q <= ST_SETTLE;
                    cnt_q   <= settle_buf_q;
                end
            end else begin
                case (state_q)
                    ST_SETTLE: begin
                        if (cnt_q == CNT_W'(1)) begin
                            state_q <= ST_MEASURE;
                            cnt_q   <= win_cur_q;
                        end else begin
                            cnt_q <= cnt_q - CNT_W'(1);
                        end
                    end
                    ST_MEASURE: begin
                        first_q <= 1'b0;
                        if (first_q) begin
                            min_q <= adc_data;
                            max_q <= adc_data;
                        end else begin
                            if (adc_data < min_q) min_q <= adc_data;
                            if (adc_data > max_q) max_q <= adc_data;
                        end
                        if (cnt_q == CNT_W'(1)) begin
                            state_q <= ST_PUSH;
                            cnt_q   <= '0;
                        end else begin
                            cnt_q <= cnt_q - CNT_W'(1);
                        end
                    end
                    ST_PUSH: begin
                        state_q <= ST_WAIT;
                        busy_q  <= 1'b0;
                    end
                    default: begin
                        state_q <= state_q;
                    end
                endcase
            end
        end
    end

    // Sticky drop flag; only reset clears it
    always_ff @(posedge clk) begin
        if (!rstn) begin
            overflow_q <= 1'b0;
        end else if (push_en && fifo_full) begin
            overflow_q <= 1'b1;
        end
    end

    sweep_capture_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (ENTRY_W)
    ) u_fifo (
        .clk     (clk),
        .rstn    (rstn),
        .push_i  (push_en),
        .wdata_i (fifo_wdata),
        .pop_i   (out_ready),
        .rdata_o (fifo_rdata),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .level_o (fifo_level)
    );

    assign out_valid = !fifo_empty;
    assign out_fword = fifo_rdata[ENTRY_W-1:ADC_W];
    assign out_pp    = fifo_rdata[ADC_W-1:0];
    assign overflow  = overflow_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_sweep_capture.sv
// tb/tb_sweep_capture.sv - scoreboard bench for sweep_capture
module tb_sweep_capture;

    localparam int DEPTH = 16;
    localparam int AW    = 12;

    logic          clk = 1'b0;
    logic          rstn;
    logic          param_wen;
    logic [15:0]   settle_cycles;
    logic [15:0]   window_cycles;
    logic          cap_en;
    logic [31:0]   fword;
    logic [AW-1:0] adc_data;
    logic          out_valid;
    logic          out_ready;
    logic [31:0]   out_fword;
    logic [AW-1:0] out_pp;
    logic [4:0]    fifo_level;
    logic          overflow;
    logic          busy;

    typedef struct packed {
        logic [31:0]   fw;
        logic [AW-1:0] pp;
    } entry_t;

    entry_t        sb_q[$];
    logic          exp_ovf = 1'b0;
    int            checks = 0;
    int            failures = 0;
    logic [AW-1:0] pp_res;

    always #5 clk = ~clk;

    sweep_capture #(
        .FIFO_DEPTH (DEPTH),
        .ADC_W      (AW)
    ) dut (
        .clk           (clk),
        .rstn          (rstn),
        .param_wen     (param_wen),
        .settle_cycles (settle_cycles),
        .window_cycles (window_cycles),
        .cap_en        (cap_en),
        .fword         (fword),
        .adc_data      (adc_data),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_fword     (out_fword),
        .out_pp        (out_pp),
        .fifo_level    (fifo_level),
        .overflow      (overflow),
        .busy          (busy)
    );

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic compare_head(input string tag);
        entry_t e;
        if (sb_q.size() == 0) begin
            check_eq({tag, "_unexpected_entry"}, 64'd1, 64'd0);
        end else begin
            e = sb_q.pop_front();
            check_eq({tag, "_fword"}, 64'(out_fword), 64'(e.fw));
            check_eq({tag, "_pp"}, 64'(out_pp), 64'(e.pp));
        end
    endtask

    task automatic expect_push(input logic [31:0] fw, input logic [AW-1:0] pp);
        entry_t e;
        e.fw = fw;
        e.pp = pp;
        if (sb_q.size() < DEPTH) sb_q.push_back(e);
        else exp_ovf = 1'b1;
    endtask

    task automatic set_params(input int s, input int w);
        settle_cycles = 16'(s);
        window_cycles = 16'(w);
        param_wen = 1'b1;
        step();
        param_wen = 1'b0;
    endtask

    // mode 0: ramp 100.. inside window, extremes outside; 1: random; 2: constant 55
    task automatic run_window(input int ncyc, input int mode, input int mlo, input int mhi,
                              input int chg_cyc, input logic [31:0] chg_word,
                              input int vcyc, input int pop_cyc, output logic [AW-1:0] pp);
        logic [AW-1:0] mn;
        logic [AW-1:0] mx;
        logic [AW-1:0] v;
        int first_v;
        first_v = -1;
        mn = '1;
        mx = '0;
        for (int c = 0; c < ncyc; c++) begin
            if (out_valid && first_v < 0) first_v = c;
            if (c == chg_cyc) fword = chg_word;
            case (mode)
                0: v = (c >= mlo && c <= mhi) ? AW'(100 + c - mlo) : (c[0] ? 12'hFFF : 12'h000);
                1: v = AW'($urandom_range(4095, 0));
                default: v = 12'd55;
            endcase
            adc_data = v;
            if (c >= mlo && c <= mhi) begin
                if (v < mn) mn = v;
                if (v > mx) mx = v;
            end
            if (c == pop_cyc) begin
                out_ready = 1'b1;
                check_eq("pushpop_valid", 64'(out_valid), 64'd1);
                compare_head("pushpop");
            end else begin
                out_ready = 1'b0;
            end
            step();
        end
        out_ready = 1'b0;
        if (vcyc >= 0) check_eq("valid_latency", 64'(first_v), 64'(vcyc));
        pp = mx - mn;
    endtask

    task automatic pop_n(input int n);
        int got;
        got = 0;
        for (int b = 0; b < 200 && got < n; b++) begin
            out_ready = 1'b1;
            if (out_valid) begin
                compare_head("pop");
                got++;
            end
            step();
        end
        out_ready = 1'b0;
        check_eq("pop_count", 64'(got), 64'(n));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        rstn = 1'b0;
        param_wen = 1'b0;
        settle_cycles = '0;
        window_cycles = '0;
        cap_en = 1'b0;
        fword = '0;
        adc_data = '0;
        out_ready = 1'b0;
        step();
        step();
        check_eq("rst_valid", 64'(out_valid), 64'd0);
        check_eq("rst_level", 64'(fifo_level), 64'd0);
        check_eq("rst_ovf", 64'(overflow), 64'd0);
        check_eq("rst_busy", 64'(busy), 64'd0);
        check_eq("rst_fword", 64'(out_fword), 64'd0);
        check_eq("rst_pp", 64'(out_pp), 64'd0);
        rstn = 1'b1;
        step();

        // Basic point: settle 4, window 8, ramp 100..107
        set_params(4, 8);
        fword = 32'h1000;
        cap_en = 1'b1;
        run_window(16, 0, 5, 12, -1, 32'h0, 14, -1, pp_res);
        expect_push(32'h1000, 12'd7);
        check_eq("t1_level", 64'(fifo_level), 64'd1);
        check_eq("t1_busy_wait", 64'(busy), 64'd0);
        pop_n(1);
        check_eq("t1_level_after", 64'(fifo_level), 64'd0);

        // Word change at third MEASURE sample aborts the point
        cap_en = 1'b0;
        step();
        cap_en = 1'b1;
        run_window(24, 1, 12, 19, 7, 32'h2000, 21, -1, pp_res);
        expect_push(32'h2000, pp_res);
        check_eq("t2_level", 64'(fifo_level), 64'd1);
        pop_n(1);

        // Zero settle and zero window
        set_params(0, 0);
        run_window(6, 2, 1, 1, 0, 32'h0ABC, 3, -1, pp_res);
        expect_push(32'h0ABC, 12'd0);
        pop_n(1);

        // Overflow with consumer stalled
        set_params(1, 3);
        for (int i = 0; i < 17; i++) begin
            run_window(6, 1, 2, 4, 0, 32'h100 + 32'(i), -1, -1, pp_res);
            expect_push(32'h100 + 32'(i), pp_res);
        end
        check_eq("t4_level_full", 64'(fifo_level), 64'd16);
        check_eq("t4_ovf", 64'(overflow), 64'(exp_ovf));

        // Simultaneous push and pop at level 5
        pop_n(11);
        check_eq("t5_level_pre", 64'(fifo_level), 64'd5);
        run_window(7, 1, 2, 4, 0, 32'h5555, -1, 5, pp_res);
        expect_push(32'h5555, pp_res);
        check_eq("t5_level_post", 64'(fifo_level), 64'd5);
        pop_n(5);
        check_eq("t5_level_empty", 64'(fifo_level), 64'd0);
        check_eq("t5_valid_empty", 64'(out_valid), 64'd0);

        // cap_en dropped mid-MEASURE, then reset with data held
        for (int i = 0; i < 3; i++) begin
            run_window(6, 1, 2, 4, 0, 32'h600 + 32'(i), -1, -1, pp_res);
            expect_push(32'h600 + 32'(i), pp_res);
        end
        check_eq("t6_level3", 64'(fifo_level), 64'd3);
        fword = 32'h7777;
        step();
        step();
        check_eq("t6_busy_measure", 64'(busy), 64'd1);
        step();
        cap_en = 1'b0;
        repeat (10) step();
        check_eq("t6_level_no_push", 64'(fifo_level), 64'd3);
        check_eq("t6_busy_idle", 64'(busy), 64'd0);
        check_eq("t6_ovf_sticky", 64'(overflow), 64'(exp_ovf));
        rstn = 1'b0;
        step();
        step();
        rstn = 1'b1;
        step();
        sb_q.delete();
        exp_ovf = 1'b0;
        check_eq("t6_rst_level", 64'(fifo_level), 64'd0);
        check_eq("t6_rst_valid", 64'(out_valid), 64'd0);
        check_eq("t6_rst_ovf", 64'(overflow), 64'(exp_ovf));
        check_eq("t6_rst_fword", 64'(out_fword), 64'd0);
        check_eq("t6_rst_pp", 64'(out_pp), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/sweep_capture.md
SWEEP_CAPTURE -- requirements
Module: sweep_capture

Interface
REQ-001 Parameter FIFO_DEPTH, default 16, result FIFO entries; power of two, 4..64.
REQ-002 Parameter ADC_W, default 12, ADC sample width, unsigned.
REQ-003 clk  in  1  clock; the single clock domain for all logic.
REQ-004 rstn  in  1  reset, synchronous, active-low.
REQ-005 param_wen  in  1  latch settle_cycles/window_cycles into internal buffers.
REQ-006 settle_cycles  in  16  cycles ignored after each tuning-word change.
REQ-007 window_cycles  in  16  samples per measurement; 0 treated as 1.
REQ-008 cap_en  in  1  capture enable, level.
REQ-009 fword  in  32  DDS frequency tuning word driven by the ramp generator.
REQ-010 adc_data  in  ADC_W  detector/ADC sample, valid every cycle.
REQ-011 out_valid  out  1  result available.
REQ-012 out_ready  in  1  consumer accepts result.
REQ-013 out_fword  out  32  tuning word of the head result.
REQ-014 out_pp  out  ADC_W  peak-to-peak (max-min) of the head result.
REQ-015 fifo_level  out  $clog2(FIFO_DEPTH)+1  entries held.
REQ-016 overflow  out  1  sticky; a result was dropped on a full FIFO.
REQ-017 busy  out  1  high in SETTLE, MEASURE, PUSH.

Function
REQ-018 State machine: IDLE, WAIT, SETTLE, MEASURE, PUSH.
REQ-019 fword_q registers fword every cycle; change = (fword != fword_q).
REQ-020 IDLE: cap_en=1 -> SETTLE (current fword treated as a new point); else stay.
REQ-021 WAIT: change -> SETTLE; else stay.
REQ-022 SETTLE: counts settle_buf cycles (0 = skip, go to MEASURE next cycle), then MEASURE.
REQ-023 MEASURE: samples adc_data for max(window_buf,1) consecutive cycles, tracking running min/max; first sample initialises both; then PUSH.
REQ-024 PUSH: one cycle; writes {point_fword, max-min} to the FIFO; then WAIT.
REQ-025 point_fword = fword_q value at SETTLE entry.
REQ-026 change during SETTLE or MEASURE aborts the point, nothing pushed, restarts SETTLE with the new word.
REQ-027 change during PUSH: push completes; next state SETTLE instead of WAIT.
REQ-028 cap_en=0 in any state -> IDLE next cycle; in-flight point discarded; FIFO contents retained.
REQ-029 Latency: change at cycle t, settle S, window W -> PUSH at t+S+W+1; out_valid at t+S+W+2 when FIFO was empty.
REQ-030 FIFO first-word-fall-through; out_fword/out_pp show head whenever out_valid=1; pop on out_valid&out_ready.
REQ-031 Push with FIFO full: result dropped, overflow set, even if a pop occurs the same cycle.
REQ-032 Simultaneous push and pop when not full: both performed, level unchanged.
REQ-033 Pop with FIFO empty: ignored (out_valid=0).
REQ-034 param_wen takes effect for the next SETTLE entry; an in-progress point uses previously latched values.
REQ-035 max-min computed unsigned, ADC_W bits, never negative.

Reset
REQ-036 rstn=0: state IDLE, counters 0, FIFO empty, out_valid=0, fifo_level=0, overflow=0, busy=0, settle/window buffers 0, fword_q 0.
REQ-037 Reset mid-point or with FIFO data: all discarded; out_fword/out_pp read 0 after reset.
REQ-038 overflow clears only by reset.

Structure
REQ-039 Package sweep_capture_pkg holds the state enum, the 16-bit counter width constant and FIFO entry width (32+ADC_W).
REQ-040 One sub-module sweep_capture_fifo: synchronous FWFT FIFO, parameters DEPTH and WIDTH, full/empty/level outputs.

Verification
REQ-041 settle=4, window=8, cap_en rise with fword=0x1000, adc=100..107 in MEASURE -> one entry {0x1000, 7}, out_valid at cycle 14 after rise.
REQ-042 fword 0x1000->0x2000 at MEASURE sample 3 -> no 0x1000 entry; single entry 0x2000 after a full new settle+window.
REQ-043 out_ready=0, 17 points at depth 16 -> fifo_level=16, overflow=1, first 16 entries read back in order.
REQ-044 window=0, settle=0, adc constant 55 -> entry pp=0, PUSH 2 cycles after change.
REQ-045 cap_en dropped mid-MEASURE, rstn pulsed while FIFO holds 3 entries -> no new push; after reset level=0, out_valid=0, overflow=0.
REQ-046 Push and pop same cycle at level 5 -> level stays 5, popped entry is oldest.
